// File: rtl/frame_write_ctrl.sv
// Frame capture controller: moves one frame of valid/ready pixels into image BRAM,
// driving write enable/data and the external address counter's clear/increment.
module frame_write_ctrl #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic             mem_we,
  output logic [PIX_W-1:0] mem_wdata,
  output logic             addr_add,
  output logic             addr_clr,
  output logic [15:0]      col,
  output logic [15:0]      row,
  output logic             busy,
  output logic             frame_done,
  output logic             sof_err
);

  localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SYNC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_write;
  logic               w_last;
  logic               w_start_go;
  logic               w_sof_hit;
  logic               r_we;
  logic [PIX_W-1:0]   r_wdata;
  logic [15:0]        r_col;
  logic [15:0]        r_row;
  logic               r_sof_err;
  logic               r_done;

  assign pix_ready  = (r_state == S_SYNC) || (r_state == S_WRITE);
  assign w_accept   = pix_valid & pix_ready;
  assign w_last     = (r_col == COL_LAST) && (r_row == ROW_LAST);
  assign w_start_go = (r_state == S_IDLE) & start & ~abort;
  assign w_sof_hit  = (r_state == S_WRITE) & w_accept & pix_sof & ~abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Abort outranks everything outside IDLE; a pixel accepted alongside it is dropped.
  always_comb begin
    w_next  = r_state;
    w_write = 1'b0;
    if (abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort) w_next = S_CLR;
        end
        S_CLR: begin
          w_next = S_SYNC;
        end
        S_SYNC: begin
          if (w_accept && pix_sof) begin
            w_write = 1'b1;
            w_next  = S_WRITE;
          end
        end
        S_WRITE: begin
          if (w_accept) begin
            w_write = 1'b1;
            if (w_last) w_next = S_DONE;
          end
        end
        S_DONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // Write port is one cycle behind the accept; the counter increments with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) r_wdata <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if (w_start_go) begin
      r_col <= 16'd0;
      r_row <= 16'd0;
    end else if (w_write) begin
      if (r_col == COL_LAST) begin
        r_col <= 16'd0;
        r_row <= (r_row == ROW_LAST) ? 16'd0 : r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
    end
  end

  // frame_done trails the DONE state so it lands the cycle after the final write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sof_err <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE) && !abort;
      if (w_start_go) begin
        r_sof_err <= 1'b0;
      end else if (w_sof_hit) begin
        r_sof_err <= 1'b1;
      end
    end
  end

  assign mem_we     = r_we;
  assign addr_add   = r_we;
  assign mem_wdata  = r_wdata;
  assign addr_clr   = (r_state == S_CLR);
  assign busy       = (r_state != S_IDLE);
  assign col        = r_col;
  assign row        = r_row;
  assign frame_done = r_done;
  assign sof_err    = r_sof_err;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Scoreboard bench for frame_write_ctrl on a 4x2 frame with a modelled address
// counter and BRAM; directed scenarios followed by randomized traffic.
module tb_frame_write_ctrl;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [7:0]  pix_data = 8'h00;
  logic        pix_ready;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        addr_add;
  logic        addr_clr;
  logic [15:0] col;
  logic [15:0] row;
  logic        busy;
  logic        frame_done;
  logic        sof_err;

  frame_write_ctrl #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .pix_ready(pix_ready), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .addr_add(addr_add), .addr_clr(addr_clr), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int addr;
    int data;
    int col;
    int row;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc_cnt = 0;
  int  n_we = 0;

  logic [15:0] tb_addr = 16'd0;
  logic [7:0]  bram [0:15];

  // Reference model: frame-level view of what the controller should be doing.
  bit m_inframe, m_fin, m_synced, m_sof_err;
  int m_age, m_idx;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(posedge clk) begin
    if (addr_clr) tb_addr <= 16'd0;
    else if (addr_add) tb_addr <= tb_addr + 16'd1;
    if (mem_we) bram[tb_addr[3:0]] <= mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_inframe = 0; m_fin = 0; m_synced = 0; m_sof_err = 0;
    m_age = 0; m_idx = 0;
    wq.delete();
    dq.delete();
  endtask

  always @(negedge clk) begin : mon
    wr_t e;
    if (reset) begin
      chk("we_eq_add", mem_we, addr_add);
      while (wq.size() > 0 && wq[0].cyc < cyc_cnt) begin
        e = wq.pop_front();
        chk("missed_write", 0, 1);
      end
      while (dq.size() > 0 && dq[0] < cyc_cnt) begin
        void'(dq.pop_front());
        chk("missed_done", frame_done, 1);
      end
      if (mem_we) begin
        n_we++;
        if (wq.size() == 0) begin
          chk("unexpected_write", mem_we, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_cycle", cyc_cnt, e.cyc);
          chk("wr_addr", tb_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_col", col, e.col);
          chk("wr_row", row, e.row);
        end
      end
      if (frame_done) begin
        if (dq.size() == 0) chk("unexpected_done", frame_done, 0);
        else chk("done_cycle", cyc_cnt, dq.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic st, input logic ab, output logic acc);
    wr_t w;
    int  p;
    logic rdy;
    @(negedge clk);
    pix_valid = v; pix_sof = s; pix_data = d; start = st; abort = ab;
    #1;
    acc = 1'b0;
    if (reset) begin
      rdy = m_inframe && (m_age >= 1) && !m_fin;
      acc = v && rdy;
      chk("pix_ready", pix_ready, rdy);
      chk("busy", busy, m_inframe);
      chk("addr_clr", addr_clr, m_inframe && (m_age == 0));
      chk("sof_err", sof_err, m_sof_err);
      if (m_inframe) begin
        if (ab) begin
          m_inframe = 0; m_fin = 0;
        end else if (m_fin) begin
          m_inframe = 0; m_fin = 0;
          dq.push_back(cyc_cnt + 1);
        end else begin
          if (acc && (m_synced || s)) begin
            if (m_synced && s) m_sof_err = 1;
            m_synced = 1;
            p = (m_idx + 1) % N;
            w.cyc = cyc_cnt + 1; w.addr = m_idx; w.data = int'(d);
            w.col = p % W; w.row = p / W;
            wq.push_back(w);
            m_idx++;
            if (m_idx == N) m_fin = 1;
          end
          if (m_age < 3) m_age++;
        end
      end else if (st && !ab) begin
        m_inframe = 1; m_age = 0; m_idx = 0; m_synced = 0; m_sof_err = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0, 0, a);
  endtask

  task automatic send_pix(input logic s, input logic [7:0] d);
    logic a;
    int   n;
    n = 0;
    do begin
      step(1, s, d, 0, 0, a);
      n++;
    end while (!a && n < 20);
  endtask

  task automatic do_start();
    logic a;
    step(0, 0, 8'h00, 1, 0, a);
  endtask

  task automatic check_bram(input string nm, input logic [7:0] base);
    for (int i = 0; i < N; i++) chk(nm, bram[i], base + 8'(i));
  endtask

  initial begin
    int   n0;
    logic a;
    logic v, s, st, ab;
    logic [7:0] d;
    m_clear();
    #3;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_addr_clr", addr_clr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_col", col, 0);
    chk("rst_row", row, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_sof_err", sof_err, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: clean back-to-back frame
    n0 = n_we;
    do_start();
    for (int i = 0; i < N; i++) send_pix(i == 0, 8'h10 + 8'(i));
    idle(3);
    chk("t1_we_count", n_we - n0, N);
    chk("t1_counter", tb_addr, N);
    check_bram("t1_bram", 8'h10);

    // 2: pixels before sof are dropped
    n0 = n_we;
    do_start();
    for (int i = 0; i < 3; i++) send_pix(0, 8'hA0 + 8'(i));
    for (int i = 0; i < N; i++) send_pix(i == 0, 8'h20 + 8'(i));
    idle(3);
    chk("t2_we_count", n_we - n0, N);
    check_bram("t2_bram", 8'h20);

    // 3: valid toggling every other cycle
    do_start();
    for (int i = 0; i < N; i++) begin
      step(0, 0, 8'h00, 0, 0, a);
      send_pix(i == 0, 8'h30 + 8'(i));
    end
    idle(3);
    chk("t3_counter", tb_addr, N);
    check_bram("t3_bram", 8'h30);

    // 4: stray sof mid-frame
    do_start();
    for (int i = 0; i < N; i++) send_pix(i == 0 || i == 4, 8'h40 + 8'(i));
    idle(3);
    chk("t4_sof_err_sticky", sof_err, 1);
    check_bram("t4_bram", 8'h40);
    do_start();
    idle(1);
    chk("t4_sof_err_cleared", sof_err, 0);

    // 5: abort after three writes, with a pixel offered in the abort cycle
    n0 = n_we;
    for (int i = 0; i < 3; i++) send_pix(i == 0, 8'hC0 + 8'(i));
    step(1, 0, 8'hEE, 0, 1, a);
    idle(3);
    chk("t5_we_after_abort", n_we - n0, 3);
    chk("t5_counter_held", tb_addr, 3);
    do_start();
    for (int i = 0; i < N; i++) send_pix(i == 0, 8'h50 + 8'(i));
    idle(3);
    chk("t5_counter", tb_addr, N);
    check_bram("t5_bram", 8'h50);

    // 6: asynchronous reset in the middle of a frame
    do_start();
    for (int i = 0; i < 5; i++) send_pix(i == 0, 8'h70 + 8'(i));
    #1 reset = 1'b0;
    #1;
    chk("t6_mem_we", mem_we, 0);
    chk("t6_addr_add", addr_add, 0);
    chk("t6_mem_wdata", mem_wdata, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pix_ready", pix_ready, 0);
    chk("t6_col", col, 0);
    chk("t6_row", row, 0);
    m_clear();
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    do_start();
    for (int i = 0; i < N; i++) send_pix(i == 0, 8'h60 + 8'(i));
    idle(3);
    check_bram("t6_bram", 8'h60);

    // Randomized traffic: stalls, stray sof, spurious start, occasional abort
    for (int f = 0; f < 8; f++) begin
      do_start();
      for (int c = 0; c < 50; c++) begin
        v  = ($urandom_range(0, 9) < 7);
        s  = ($urandom_range(0, 4) == 0);
        d  = 8'($urandom);
        st = ($urandom_range(0, 15) == 0);
        ab = ($urandom_range(0, 79) == 0);
        step(v, s, d, st, ab, a);
      end
      idle(5);
    end

    chk("pending_writes", wq.size(), 0);
    chk("pending_done", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
